// File: rtl/accum_buf_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : accum_buf_ctrl_if
//  Description : Bundle of the descriptor, load/store stream, buffer port-B
//                and compute-handshake signals around accum_buf_ctrl.
//                master = environment side, slave = the controller.
//  Revision    : 1.0 - initial release
// ============================================================================
interface accum_buf_ctrl_if #(
    parameter int DEPTH  = 256,
    parameter int BATCH  = 32,
    parameter int DATA_W = 16,
    parameter int TAIL_W = 8,
    parameter int RES_W  = DATA_W + TAIL_W,
    parameter int ADDR_W = $clog2(DEPTH)
);
    logic                      cfg_valid;
    logic                      cfg_ready;
    logic [ADDR_W:0]           cfg_len;
    logic                      cfg_store;
    logic                      cfg_load;
    logic                      cfg_ld_tail;
    logic                      ld_valid;
    logic                      ld_ready;
    logic [BATCH*DATA_W-1:0]   ld_data;
    logic [BATCH*TAIL_W-1:0]   ld_tail;
    logic                      st_valid;
    logic                      st_ready;
    logic [BATCH*RES_W-1:0]    st_data;
    logic                      buf_switch;
    logic [ADDR_W-1:0]         buf_wr_addr;
    logic [BATCH*DATA_W-1:0]   buf_wr_data;
    logic                      buf_wr_data_en;
    logic [BATCH*TAIL_W-1:0]   buf_wr_tail;
    logic                      buf_wr_tail_en;
    logic [ADDR_W-1:0]         buf_rd_addr;
    logic                      buf_rd_en;
    logic [BATCH*RES_W-1:0]    buf_rd_data;
    logic                      comp_start;
    logic                      comp_done;

    modport master (
        output cfg_valid, cfg_len, cfg_store, cfg_load, cfg_ld_tail,
        output ld_valid, ld_data, ld_tail, st_ready, buf_rd_data, comp_done,
        input  cfg_ready, ld_ready, st_valid, st_data, buf_switch,
        input  buf_wr_addr, buf_wr_data, buf_wr_data_en, buf_wr_tail, buf_wr_tail_en,
        input  buf_rd_addr, buf_rd_en, comp_start
    );

    modport slave (
        input  cfg_valid, cfg_len, cfg_store, cfg_load, cfg_ld_tail,
        input  ld_valid, ld_data, ld_tail, st_ready, buf_rd_data, comp_done,
        output cfg_ready, ld_ready, st_valid, st_data, buf_switch,
        output buf_wr_addr, buf_wr_data, buf_wr_data_en, buf_wr_tail, buf_wr_tail_en,
        output buf_rd_addr, buf_rd_en, comp_start
    );
endinterface
`default_nettype wire

// File: rtl/accum_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : accum_buf_ctrl
//  Description : Back-bank sequencer of the PE ping-pong accumulation buffer.
//                Drains finished results to the store stream, preloads partial
//                sums from the load stream, then swaps banks and kicks off the
//                next compute pass once compute has also finished.
//  Revision    : 1.0 - initial release
// ============================================================================
module accum_buf_ctrl #(
    parameter int DEPTH  = 256,
    parameter int BATCH  = 32,
    parameter int DATA_W = 16,
    parameter int TAIL_W = 8,
    parameter int RES_W  = DATA_W + TAIL_W,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int RD_LAT = 2
) (
    input  wire logic          clk,
    input  wire logic          rst,
    accum_buf_ctrl_if.slave    bus
);
    localparam int              c_FIFO_D = RD_LAT + 1;
    localparam int              c_PTR_W  = $clog2(c_FIFO_D);
    localparam int              c_CNT_W  = $clog2(c_FIFO_D + 1);
    localparam int              c_OUT_W  = $clog2(RD_LAT + 2);
    localparam int              c_WORD_W = BATCH * RES_W;
    localparam logic [ADDR_W:0] c_DEPTH  = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_STORE  = 3'd1,
        S_DRAIN  = 3'd2,
        S_LOAD   = 3'd3,
        S_SYNC   = 3'd4,
        S_SWITCH = 3'd5
    } state_t;

    state_t                r_state;
    state_t                w_next;
    logic                  r_live;        // low for the first cycle after reset
    logic [ADDR_W:0]       r_len;
    logic                  r_load;
    logic                  r_tail_en;
    logic [ADDR_W-1:0]     r_rd_addr;
    logic [ADDR_W-1:0]     r_wr_addr;
    logic [RD_LAT-1:0]     r_rd_pipe;     // read-return timing shadow of the RAM
    logic [c_OUT_W-1:0]    r_outst;
    logic [c_WORD_W-1:0]   r_fifo [c_FIFO_D];
    logic [c_PTR_W-1:0]    r_wptr;
    logic [c_PTR_W-1:0]    r_rptr;
    logic [c_CNT_W-1:0]    r_cnt;
    logic                  r_comp_start;
    logic                  r_comp_busy;

    logic                  w_accept;
    logic                  w_rd_fire;
    logic                  w_wr_fire;
    logic                  w_ret;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_credit;
    logic                  w_rd_last;
    logic                  w_wr_last;
    logic [ADDR_W:0]       w_len_clamped;

    assign w_len_clamped = (bus.cfg_len > c_DEPTH) ? c_DEPTH : bus.cfg_len;
    assign w_ret         = r_rd_pipe[RD_LAT-1];
    // A read slot is free only if its data is guaranteed a FIFO entry.
    assign w_credit      = (32'(r_outst) + 32'(r_cnt)) < 32'(c_FIFO_D);
    assign w_rd_last     = ({1'b0, r_rd_addr} + (ADDR_W + 1)'(1)) == r_len;
    assign w_wr_last     = ({1'b0, r_wr_addr} + (ADDR_W + 1)'(1)) == r_len;
    // Returning data skips the FIFO when it is empty and the sink is ready.
    assign w_push        = w_ret && !((r_cnt == '0) && bus.st_ready);
    assign w_pop         = (r_cnt != '0) && bus.st_ready;

    assign bus.buf_rd_en      = w_rd_fire;
    assign bus.buf_rd_addr    = r_rd_addr;
    assign bus.buf_wr_addr    = r_wr_addr;
    assign bus.buf_wr_data_en = w_wr_fire;
    assign bus.buf_wr_tail_en = w_wr_fire;
    assign bus.buf_wr_data    = w_wr_fire ? bus.ld_data : '0;
    assign bus.buf_wr_tail    = (w_wr_fire && r_tail_en) ? bus.ld_tail : '0;
    assign bus.st_valid       = (r_cnt != '0) || w_ret;
    assign bus.st_data        = (r_cnt != '0) ? r_fifo[r_rptr] : (w_ret ? bus.buf_rd_data : '0);
    assign bus.comp_start     = r_comp_start;

    // Next-state decode and per-state handshake outputs.
    always_comb begin
        w_next         = r_state;
        w_accept       = 1'b0;
        w_rd_fire      = 1'b0;
        w_wr_fire      = 1'b0;
        bus.cfg_ready  = 1'b0;
        bus.ld_ready   = 1'b0;
        bus.buf_switch = 1'b0;
        case (r_state)
            S_IDLE: begin
                bus.cfg_ready = r_live;
                if (r_live && bus.cfg_valid) begin
                    w_accept = 1'b1;
                    if (bus.cfg_store && (w_len_clamped != '0))     w_next = S_STORE;
                    else if (bus.cfg_load && (w_len_clamped != '0)) w_next = S_LOAD;
                    else                                            w_next = S_SYNC;
                end
            end
            S_STORE: begin
                if (w_credit) begin
                    w_rd_fire = 1'b1;
                    if (w_rd_last) w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if ((r_outst == '0) && (r_cnt == '0)) w_next = r_load ? S_LOAD : S_SYNC;
            end
            S_LOAD: begin
                bus.ld_ready = 1'b1;
                if (bus.ld_valid) begin
                    w_wr_fire = 1'b1;
                    if (w_wr_last) w_next = S_SYNC;
                end
            end
            S_SYNC: begin
                if (!r_comp_busy || bus.comp_done) w_next = S_SWITCH;
            end
            S_SWITCH: begin
                bus.buf_switch = 1'b1;
                w_next         = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // State register, descriptor latch and address counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= S_IDLE;
            r_live    <= 1'b0;
            r_len     <= '0;
            r_load    <= 1'b0;
            r_tail_en <= 1'b0;
            r_rd_addr <= '0;
            r_wr_addr <= '0;
        end else begin
            r_state <= w_next;
            r_live  <= 1'b1;
            if (w_accept) begin
                r_len     <= w_len_clamped;
                r_load    <= bus.cfg_load;
                r_tail_en <= bus.cfg_ld_tail;
                r_rd_addr <= '0;
                r_wr_addr <= '0;
            end else begin
                if (w_rd_fire) r_rd_addr <= r_rd_addr + 1'b1;
                if (w_wr_fire) r_wr_addr <= r_wr_addr + 1'b1;
            end
        end
    end

    // Read-latency tracking and skid-FIFO bookkeeping.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rd_pipe <= '0;
            r_outst   <= '0;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_cnt     <= '0;
        end else begin
            r_rd_pipe <= (r_rd_pipe << 1) | RD_LAT'(w_rd_fire);
            r_outst   <= r_outst + c_OUT_W'(w_rd_fire) - c_OUT_W'(w_ret);
            r_cnt     <= r_cnt + c_CNT_W'(w_push) - c_CNT_W'(w_pop);
            if (w_push) r_wptr <= (32'(r_wptr) == c_FIFO_D - 1) ? '0 : r_wptr + 1'b1;
            if (w_pop)  r_rptr <= (32'(r_rptr) == c_FIFO_D - 1) ? '0 : r_rptr + 1'b1;
        end
    end

    // Skid-FIFO storage; contents are don't-care while the count is zero.
    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= bus.buf_rd_data;
    end

    // Compute handshake: start pulse follows the switch, busy spans the pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_comp_start <= 1'b0;
            r_comp_busy  <= 1'b0;
        end else begin
            r_comp_start <= (r_state == S_SWITCH);
            if (r_comp_start)       r_comp_busy <= 1'b1;
            else if (bus.comp_done) r_comp_busy <= 1'b0;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_accum_buf_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_accum_buf_ctrl
//  Description : Directed self-checking bench for accum_buf_ctrl with a
//                2-cycle-latency buffer model and an event monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_accum_buf_ctrl;
    localparam int DEPTH  = 256;
    localparam int BATCH  = 32;
    localparam int DATA_W = 16;
    localparam int TAIL_W = 8;
    localparam int RES_W  = DATA_W + TAIL_W;
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int RD_LAT = 2;

    logic clk;
    logic rst;

    accum_buf_ctrl_if #(.DEPTH(DEPTH), .BATCH(BATCH), .DATA_W(DATA_W), .TAIL_W(TAIL_W),
                        .RES_W(RES_W), .ADDR_W(ADDR_W)) bus ();

    accum_buf_ctrl #(.DEPTH(DEPTH), .BATCH(BATCH), .DATA_W(DATA_W), .TAIL_W(TAIL_W),
                     .RES_W(RES_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;
    int cyc_n = 0, pcnt = 0, st_mode = 1, exp_tail_on = 0;
    int rd_n = 0, wr_n = 0, st_n = 0, sw_n = 0, cs_n = 0;
    int rd_base = 0, wr_base = 0, st_base = 0, sw_base = 0, cs_base = 0;
    int first_rd = 0, last_rd = 0, first_wr = 0, last_wr = 0;
    int sw_cyc = 0, cs_cyc = 0, acc_cyc = 0, done_cyc = 0;
    logic [BATCH*RES_W-1:0] e_w;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [BATCH*DATA_W-1:0] pat_d(int k);
        logic [BATCH*DATA_W-1:0] r;
        for (int i = 0; i < BATCH; i++) r[i*DATA_W +: DATA_W] = DATA_W'(k * 3 + 1 + i);
        return r;
    endfunction

    function automatic logic [BATCH*TAIL_W-1:0] pat_t(int k);
        logic [BATCH*TAIL_W-1:0] r;
        for (int i = 0; i < BATCH; i++) r[i*TAIL_W +: TAIL_W] = TAIL_W'(k ^ 8'h5a ^ i);
        return r;
    endfunction

    function automatic logic [BATCH*RES_W-1:0] tagw(int a);
        logic [BATCH*RES_W-1:0] r;
        for (int i = 0; i < BATCH; i++) r[i*RES_W +: RES_W] = {8'(i), 16'(a)};
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Buffer port-B model: returns addr-tagged data RD_LAT cycles after a read.
    logic              mv1 = 1'b0, mv2 = 1'b0;
    logic [ADDR_W-1:0] ma1 = '0, ma2 = '0;
    always @(posedge clk) begin
        mv1 <= bus.buf_rd_en;
        ma1 <= bus.buf_rd_addr;
        mv2 <= mv1;
        ma2 <= ma1;
    end
    assign bus.buf_rd_data = mv2 ? tagw(int'(ma2)) : '0;

    // Event monitor: counts traffic and checks every beat as it happens.
    always @(negedge clk) begin
        cyc_n++;
        if (bus.cfg_valid && bus.cfg_ready) acc_cyc = cyc_n;
        if (bus.comp_done) done_cyc = cyc_n;
        if (bus.buf_rd_en || bus.buf_wr_data_en || bus.buf_wr_tail_en)
            chk("port_sep", 32'(bus.buf_rd_en & (bus.buf_wr_data_en | bus.buf_wr_tail_en)), 0);
        if (bus.buf_rd_en) begin
            chk("rd_addr", 32'(bus.buf_rd_addr), 32'(rd_n - rd_base));
            chk("inflight_le3", ((rd_n - rd_base) - (st_n - st_base) + 1 <= 3) ? 1 : 0, 1);
            if (rd_n == rd_base) first_rd = cyc_n;
            last_rd = cyc_n;
            rd_n++;
        end
        if (bus.buf_wr_data_en) begin
            chk("wr_addr", 32'(bus.buf_wr_addr), 32'(wr_n - wr_base));
            chk("wr_data", (bus.buf_wr_data === pat_d(wr_n - wr_base)) ? 1 : 0, 1);
            chk("wr_tail", (bus.buf_wr_tail === (exp_tail_on != 0 ? pat_t(wr_n - wr_base) : '0)) ? 1 : 0, 1);
            chk("wr_tail_en", 32'(bus.buf_wr_tail_en), 1);
            if (wr_n == wr_base) first_wr = cyc_n;
            last_wr = cyc_n;
            wr_n++;
        end
        if (bus.st_valid && bus.st_ready) begin
            e_w = tagw(st_n - st_base);
            chk("st_word", (bus.st_data === e_w) ? 1 : 0, 1);
            chk("st_lane0", 32'(bus.st_data[RES_W-1:0]), 32'(e_w[RES_W-1:0]));
            st_n++;
        end
        if (bus.buf_switch) begin
            sw_cyc = cyc_n;
            sw_n++;
        end
        if (bus.comp_start) begin
            cs_cyc = cyc_n;
            cs_n++;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        pcnt++;
        case (st_mode)
            0:       bus.st_ready = 1'b0;
            1:       bus.st_ready = 1'b1;
            default: bus.st_ready = ((pcnt % 4) == 0) || ((pcnt % 4) == 3);
        endcase
        bus.ld_data = pat_d(wr_n - wr_base);
        bus.ld_tail = pat_t(wr_n - wr_base);
    endtask

    task automatic snap();
        rd_base = rd_n; wr_base = wr_n; st_base = st_n; sw_base = sw_n; cs_base = cs_n;
    endtask

    task automatic do_cfg(input int len, input bit st, input bit ld, input bit tl);
        int n;
        cyc();
        bus.cfg_valid = 1'b1; bus.cfg_len = (ADDR_W + 1)'(len);
        bus.cfg_store = st; bus.cfg_load = ld; bus.cfg_ld_tail = tl;
        n = 0;
        forever begin
            @(negedge clk);
            if (bus.cfg_ready || n > 20) break;
            cyc();
            n++;
        end
        chk("cfg_accept", 32'(bus.cfg_ready), 1);
        cyc();
        bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_cs(input int budget);
        int n;
        n = 0;
        while (cs_n == cs_base && n < budget) begin
            cyc();
            n++;
        end
        chk("round_done", 32'(cs_n - cs_base), 1);
    endtask

    task automatic pulse_done();
        cyc();
        bus.comp_done = 1'b1;
        cyc();
        bus.comp_done = 1'b0;
    endtask

    initial begin
        int n;
        rst = 1'b0;
        bus.cfg_valid = 1'b0; bus.cfg_len = '0; bus.cfg_store = 1'b0; bus.cfg_load = 1'b0;
        bus.cfg_ld_tail = 1'b0; bus.ld_valid = 1'b0; bus.ld_data = '0; bus.ld_tail = '0;
        bus.st_ready = 1'b1; bus.comp_done = 1'b0;

        // Reset state
        repeat (3) cyc();
        @(negedge clk);
        chk("rst_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("rst_st_valid", 32'(bus.st_valid), 0);
        chk("rst_switch", 32'(bus.buf_switch), 0);
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("rel_cfg_ready0", 32'(bus.cfg_ready), 0);
        cyc();
        @(negedge clk);
        chk("rel_cfg_ready1", 32'(bus.cfg_ready), 1);

        // Load only, len=4, tails passed through
        snap(); exp_tail_on = 1; bus.ld_valid = 1'b1;
        do_cfg(4, 1'b0, 1'b1, 1'b1);
        wait_cs(50);
        bus.ld_valid = 1'b0;
        chk("t1_wr_cnt", 32'(wr_n - wr_base), 4);
        chk("t1_first_wr", 32'(first_wr), 32'(acc_cyc + 1));
        chk("t1_wr_span", 32'(last_wr - first_wr), 3);
        chk("t1_sw_cyc", 32'(sw_cyc), 32'(last_wr + 2));
        chk("t1_sw_cnt", 32'(sw_n - sw_base), 1);
        chk("t1_cs_cyc", 32'(cs_cyc), 32'(sw_cyc + 1));
        chk("t1_rd_cnt", 32'(rd_n - rd_base), 0);

        // Back side finishes while compute is busy
        snap();
        do_cfg(0, 1'b0, 1'b0, 1'b0);
        repeat (10) cyc();
        chk("t5_hold_sw", 32'(sw_n - sw_base), 0);
        pulse_done();
        wait_cs(20);
        chk("t5_sw_after_done", 32'(sw_cyc), 32'(done_cyc + 1));
        chk("t5_cs_cyc", 32'(cs_cyc), 32'(sw_cyc + 1));

        // Clear busy, then a stray comp_done that must be ignored
        pulse_done();
        pulse_done();

        // Zero length with store and load requested
        snap();
        do_cfg(0, 1'b1, 1'b1, 1'b0);
        wait_cs(20);
        chk("t4_rd_cnt", 32'(rd_n - rd_base), 0);
        chk("t4_wr_cnt", 32'(wr_n - wr_base), 0);
        chk("t4_sw_cyc", 32'(sw_cyc), 32'(acc_cyc + 2));
        chk("t4_cs_cyc", 32'(cs_cyc), 32'(sw_cyc + 1));
        pulse_done();

        // Store len=8 with st_ready 1,0,0,1 repeating
        snap(); st_mode = 2;
        do_cfg(8, 1'b1, 1'b0, 1'b0);
        wait_cs(200);
        chk("t2_rd_cnt", 32'(rd_n - rd_base), 8);
        chk("t2_st_cnt", 32'(st_n - st_base), 8);
        chk("t2_sw_cnt", 32'(sw_n - sw_base), 1);
        pulse_done();

        // Full-depth store then load at full rate, tails zeroed
        snap(); st_mode = 1; exp_tail_on = 0; bus.ld_valid = 1'b1;
        do_cfg(256, 1'b1, 1'b1, 1'b0);
        wait_cs(1500);
        bus.ld_valid = 1'b0;
        chk("t3_rd_cnt", 32'(rd_n - rd_base), 256);
        chk("t3_rd_span", 32'(last_rd - first_rd), 255);
        chk("t3_first_rd", 32'(first_rd), 32'(acc_cyc + 1));
        chk("t3_st_cnt", 32'(st_n - st_base), 256);
        chk("t3_wr_cnt", 32'(wr_n - wr_base), 256);
        chk("t3_wr_span", 32'(last_wr - first_wr), 255);
        chk("t3_order", (first_wr > last_rd) ? 1 : 0, 1);
        pulse_done();

        // Reset in the middle of a store with reads in flight
        snap(); st_mode = 0;
        do_cfg(16, 1'b1, 1'b0, 1'b0);
        n = 0;
        while ((rd_n - rd_base) < 2 && n < 20) begin
            cyc();
            n++;
        end
        chk("t6_two_reads", 32'(rd_n - rd_base), 2);
        rst = 1'b0;
        cyc();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_cfg_ready", 32'(bus.cfg_ready), 0);
        chk("t6_st_valid", 32'(bus.st_valid), 0);
        chk("t6_rd_en", 32'(bus.buf_rd_en), 0);
        chk("t6_ld_ready", 32'(bus.ld_ready), 0);
        chk("t6_ctl_zero", 32'({bus.buf_switch, bus.comp_start, bus.buf_wr_data_en,
                                bus.buf_wr_tail_en}), 0);
        chk("t6_bus_zero", ((bus.st_data | bus.buf_wr_data | bus.buf_wr_tail | bus.buf_rd_addr
                             | bus.buf_wr_addr) == '0) ? 1 : 0, 1);
        cyc();
        @(negedge clk);
        chk("t6_cfg_ready_back", 32'(bus.cfg_ready), 1);
        chk("t6_stale_ignored", 32'(bus.st_valid), 0);
        repeat (5) cyc();
        chk("t6_no_switch", 32'(sw_n - sw_base), 0);
        chk("t6_no_start", 32'(cs_n - cs_base), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
